// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the RISC-V control units: state encoding,
// opcode constants and instruction-class / ALU operation codes.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_ILOGIC = 7'b0010011;
  localparam logic [6:0] OPC_U      = 7'b0110111;
  localparam logic [6:0] OPC_S      = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_B      = 7'b1100011;
  localparam logic [6:0] OPC_J      = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // The class code doubles as the ALU operation code driven in EXECUTE.
  typedef enum logic [2:0] {
    CLS_R      = 3'b000,
    CLS_ILOGIC = 3'b001,
    CLS_U      = 3'b010,
    CLS_S      = 3'b011,
    CLS_LOAD   = 3'b100,
    CLS_B      = 3'b101,
    CLS_J      = 3'b110,
    CLS_JALR   = 3'b111
  } op_class_e;

  // FETCH uses the load/add code to compute PC+4.
  localparam logic [2:0] ALU_OP_ADD = 3'b100;

endpackage

// File: rtl/op_class_decoder.sv
// Maps a 7-bit opcode to its instruction class and flags unlisted opcodes.
module op_class_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output op_class_e  cls,
  output logic       legal
);

  // Pure opcode lookup; anything not listed is illegal.
  always_comb begin
    cls   = CLS_R;
    legal = 1'b1;
    case (op)
      OPC_R:      cls = CLS_R;
      OPC_ILOGIC: cls = CLS_ILOGIC;
      OPC_U:      cls = CLS_U;
      OPC_S:      cls = CLS_S;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_B:      cls = CLS_B;
      OPC_J:      cls = CLS_J;
      OPC_JALR:   cls = CLS_JALR;
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with a
// sticky TRAP state for illegal opcodes. Outputs are forced to 0 while reset
// is low so a reset mid-transaction drops memory requests immediately.
module multicycle_control
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] OP_i,
  input  logic       Mem_Ready_i,
  output logic       PC_Write_o,
  output logic       PC_Write_Cond_o,
  output logic [1:0] PC_Src_o,
  output logic       Old_PC_Write_o,
  output logic       IorD_o,
  output logic       Mem_Read_o,
  output logic       Mem_Write_o,
  output logic       IR_Write_o,
  output logic       Reg_Write_o,
  output logic [1:0] Mem_to_Reg_o,
  output logic       ALU_Src_A_o,
  output logic [1:0] ALU_Src_B_o,
  output logic [2:0] ALU_Op_o,
  output logic       Instr_Done_o,
  output logic       Illegal_o
);

  state_e     state_q, state_d;
  logic [6:0] op_q;
  logic [6:0] dec_op;
  op_class_e  cls;
  logic       legal;

  // The live opcode is only needed for the DECODE legality decision; every
  // output is driven from the latched copy.
  assign dec_op = (state_q == ST_DECODE) ? OP_i : op_q;

  op_class_decoder u_dec (
    .op    (dec_op),
    .cls   (cls),
    .legal (legal)
  );

  // State and opcode registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      op_q    <= 7'b0000000;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) op_q <= OP_i;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:   if (Mem_Ready_i) state_d = ST_DECODE;
      ST_DECODE:  state_d = legal ? ST_EXECUTE : ST_TRAP;
      ST_EXECUTE: begin
        case (cls)
          CLS_B:           state_d = ST_FETCH;
          CLS_LOAD, CLS_S: state_d = ST_MEMORY;
          default:         state_d = ST_WRITEBACK;
        endcase
      end
      ST_MEMORY: begin
        if (Mem_Ready_i) state_d = (cls == CLS_S) ? ST_FETCH : ST_WRITEBACK;
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_TRAP:      state_d = ST_TRAP;
      default:      state_d = ST_FETCH;
    endcase
  end

  // Output decode from state, latched class and memory handshake.
  always_comb begin
    PC_Write_o      = 1'b0;
    PC_Write_Cond_o = 1'b0;
    PC_Src_o        = 2'b00;
    Old_PC_Write_o  = 1'b0;
    IorD_o          = 1'b0;
    Mem_Read_o      = 1'b0;
    Mem_Write_o     = 1'b0;
    IR_Write_o      = 1'b0;
    Reg_Write_o     = 1'b0;
    Mem_to_Reg_o    = 2'b00;
    ALU_Src_A_o     = 1'b0;
    ALU_Src_B_o     = 2'b00;
    ALU_Op_o        = 3'b000;
    Instr_Done_o    = 1'b0;
    Illegal_o       = 1'b0;
    if (reset) begin
      case (state_q)
        ST_FETCH: begin
          Mem_Read_o     = 1'b1;
          ALU_Src_B_o    = 2'b01;
          ALU_Op_o       = ALU_OP_ADD;
          IR_Write_o     = Mem_Ready_i;
          PC_Write_o     = Mem_Ready_i;
          Old_PC_Write_o = Mem_Ready_i;
        end
        ST_EXECUTE: begin
          ALU_Op_o    = cls;
          ALU_Src_A_o = (cls != CLS_U) && (cls != CLS_J);
          ALU_Src_B_o = ((cls == CLS_R) || (cls == CLS_B)) ? 2'b00 : 2'b10;
          if (cls == CLS_B) begin
            PC_Write_Cond_o = 1'b1;
            PC_Src_o        = 2'b01;
            Instr_Done_o    = 1'b1;
          end
        end
        ST_MEMORY: begin
          IorD_o       = 1'b1;
          Mem_Read_o   = (cls == CLS_LOAD);
          Mem_Write_o  = (cls == CLS_S);
          Instr_Done_o = (cls == CLS_S) && Mem_Ready_i;
        end
        ST_WRITEBACK: begin
          Reg_Write_o  = 1'b1;
          Instr_Done_o = 1'b1;
          case (cls)
            CLS_LOAD: Mem_to_Reg_o = 2'b01;
            CLS_J: begin
              Mem_to_Reg_o = 2'b10;
              PC_Write_o   = 1'b1;
              PC_Src_o     = 2'b01;
            end
            CLS_JALR: begin
              Mem_to_Reg_o = 2'b10;
              PC_Write_o   = 1'b1;
              PC_Src_o     = 2'b10;
            end
            default: Mem_to_Reg_o = 2'b00;
          endcase
        end
        ST_TRAP: Illegal_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each cycle's expected output vector
// is queued as stimulus is applied and popped when the outputs are sampled.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] OP_i;
  logic       Mem_Ready_i;
  logic       PC_Write_o, PC_Write_Cond_o, Old_PC_Write_o, IorD_o;
  logic       Mem_Read_o, Mem_Write_o, IR_Write_o, Reg_Write_o;
  logic       ALU_Src_A_o, Instr_Done_o, Illegal_o;
  logic [1:0] PC_Src_o, Mem_to_Reg_o, ALU_Src_B_o;
  logic [2:0] ALU_Op_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [20:0] v;
    string       tag;
  } exp_t;
  exp_t sb[$];

  localparam logic [6:0] JUNK = 7'b1010101;

  multicycle_control dut (
    .clk             (clk),
    .reset           (reset),
    .OP_i            (OP_i),
    .Mem_Ready_i     (Mem_Ready_i),
    .PC_Write_o      (PC_Write_o),
    .PC_Write_Cond_o (PC_Write_Cond_o),
    .PC_Src_o        (PC_Src_o),
    .Old_PC_Write_o  (Old_PC_Write_o),
    .IorD_o          (IorD_o),
    .Mem_Read_o      (Mem_Read_o),
    .Mem_Write_o     (Mem_Write_o),
    .IR_Write_o      (IR_Write_o),
    .Reg_Write_o     (Reg_Write_o),
    .Mem_to_Reg_o    (Mem_to_Reg_o),
    .ALU_Src_A_o     (ALU_Src_A_o),
    .ALU_Src_B_o     (ALU_Src_B_o),
    .ALU_Op_o        (ALU_Op_o),
    .Instr_Done_o    (Instr_Done_o),
    .Illegal_o       (Illegal_o)
  );

  always #5 clk = ~clk;

  // Field order: pcw pcwc pcsrc[2] oldpc iord mr mw irw rw m2r[2] a b[2] aluop[3] done ill
  function automatic logic [20:0] pk(logic pcw, logic pcwc, logic [1:0] pcsrc,
      logic oldpc, logic iord, logic mr, logic mw, logic irw, logic rw,
      logic [1:0] m2r, logic a, logic [1:0] b, logic [2:0] aluop, logic done, logic ill);
    return {pcw, pcwc, pcsrc, oldpc, iord, mr, mw, irw, rw, m2r, a, b, aluop, done, ill};
  endfunction

  function automatic logic [20:0] e_zero();
    return 21'd0;
  endfunction

  function automatic logic [20:0] e_fetch(logic rdy);
    return pk(rdy, 1'b0, 2'b00, rdy, 1'b0, 1'b1, 1'b0, rdy, 1'b0, 2'b00, 1'b0, 2'b01, 3'b100, 1'b0, 1'b0);
  endfunction

  // c: 000 R, 001 I, 010 U, 011 S, 100 Load, 101 B, 110 J, 111 JALR
  function automatic logic [20:0] e_exec(logic [2:0] c);
    logic       is_b;
    logic       a;
    logic [1:0] b;
    is_b = (c == 3'b101);
    a    = !((c == 3'b010) || (c == 3'b110));
    b    = ((c == 3'b000) || is_b) ? 2'b00 : 2'b10;
    return pk(1'b0, is_b, is_b ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              2'b00, a, b, c, is_b, 1'b0);
  endfunction

  function automatic logic [20:0] e_mem(logic is_load, logic rdy);
    return pk(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, is_load, !is_load, 1'b0, 1'b0, 2'b00,
              1'b0, 2'b00, 3'b000, !is_load && rdy, 1'b0);
  endfunction

  function automatic logic [20:0] e_wb(logic [2:0] c);
    logic [1:0] m2r;
    logic       pcw;
    logic [1:0] src;
    m2r = (c == 3'b100) ? 2'b01 : ((c == 3'b110) || (c == 3'b111)) ? 2'b10 : 2'b00;
    pcw = (c == 3'b110) || (c == 3'b111);
    src = (c == 3'b110) ? 2'b01 : (c == 3'b111) ? 2'b10 : 2'b00;
    return pk(pcw, 1'b0, src, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m2r, 1'b0, 2'b00,
              3'b000, 1'b1, 1'b0);
  endfunction

  function automatic logic [20:0] e_trap();
    return 21'd1;
  endfunction

  // One clock cycle: apply inputs after the edge, queue the expectation,
  // then pop and compare once combinational outputs have settled.
  task automatic cyc(input logic rst, input logic rdy, input logic [6:0] op,
                     input logic [20:0] ev, input string tag);
    exp_t        e;
    logic [20:0] obs;
    @(posedge clk);
    #1;
    reset       = rst;
    Mem_Ready_i = rdy;
    OP_i        = op;
    e.v   = ev;
    e.tag = tag;
    sb.push_back(e);
    #1;
    obs = {PC_Write_o, PC_Write_Cond_o, PC_Src_o, Old_PC_Write_o, IorD_o, Mem_Read_o,
           Mem_Write_o, IR_Write_o, Reg_Write_o, Mem_to_Reg_o, ALU_Src_A_o, ALU_Src_B_o,
           ALU_Op_o, Instr_Done_o, Illegal_o};
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%h required=queued-entry", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.v);
      end
    end
  endtask

  // Simple register-writeback instruction with an immediate memory response.
  task automatic run_wb(input logic [6:0] op, input logic [2:0] c, input string nm);
    cyc(1'b1, 1'b1, JUNK, e_fetch(1'b1), {nm, "_fetch"});
    cyc(1'b1, 1'b1, op,   e_zero(),      {nm, "_decode"});
    cyc(1'b1, 1'b0, JUNK, e_exec(c),     {nm, "_exec"});
    cyc(1'b1, 1'b0, JUNK, e_wb(c),       {nm, "_wb"});
  endtask

  initial begin
    reset       = 1'b0;
    Mem_Ready_i = 1'b0;
    OP_i        = 7'b0;

    // Reset holds outputs low regardless of inputs.
    cyc(1'b0, 1'b1, JUNK, e_zero(), "reset0");
    cyc(1'b0, 1'b0, JUNK, e_zero(), "reset1");

    // First FETCH immediately after release; hold while memory not ready.
    cyc(1'b1, 1'b0, JUNK, e_fetch(1'b0), "first_fetch_wait");
    cyc(1'b1, 1'b1, JUNK, e_fetch(1'b1), "first_fetch_rdy");
    cyc(1'b1, 1'b0, 7'b0110011, e_zero(), "r_decode");
    cyc(1'b1, 1'b0, JUNK, e_exec(3'b000), "r_exec");
    cyc(1'b1, 1'b0, JUNK, e_wb(3'b000),   "r_wb");

    // Load with two wait cycles in FETCH and in MEMORY: 9 cycles.
    cyc(1'b1, 1'b0, JUNK, e_fetch(1'b0), "ld_fetch_w1");
    cyc(1'b1, 1'b0, JUNK, e_fetch(1'b0), "ld_fetch_w2");
    cyc(1'b1, 1'b1, JUNK, e_fetch(1'b1), "ld_fetch_rdy");
    cyc(1'b1, 1'b0, 7'b0000011, e_zero(), "ld_decode");
    cyc(1'b1, 1'b0, JUNK, e_exec(3'b100), "ld_exec");
    cyc(1'b1, 1'b0, JUNK, e_mem(1'b1, 1'b0), "ld_mem_w1");
    cyc(1'b1, 1'b0, JUNK, e_mem(1'b1, 1'b0), "ld_mem_w2");
    cyc(1'b1, 1'b1, JUNK, e_mem(1'b1, 1'b1), "ld_mem_rdy");
    cyc(1'b1, 1'b0, JUNK, e_wb(3'b100),      "ld_wb");

    // Store retires from MEMORY.
    cyc(1'b1, 1'b1, JUNK, e_fetch(1'b1), "st_fetch");
    cyc(1'b1, 1'b1, 7'b0100011, e_zero(), "st_decode");
    cyc(1'b1, 1'b1, JUNK, e_exec(3'b011), "st_exec");
    cyc(1'b1, 1'b0, JUNK, e_mem(1'b0, 1'b0), "st_mem_w");
    cyc(1'b1, 1'b1, JUNK, e_mem(1'b0, 1'b1), "st_mem_rdy");

    // Branch: 3 cycles, retires from EXECUTE.
    cyc(1'b1, 1'b1, JUNK, e_fetch(1'b1), "b_fetch");
    cyc(1'b1, 1'b0, 7'b1100011, e_zero(), "b_decode");
    cyc(1'b1, 1'b0, JUNK, e_exec(3'b101), "b_exec");

    run_wb(7'b1101111, 3'b110, "j");
    run_wb(7'b1100111, 3'b111, "jalr");
    run_wb(7'b0010011, 3'b001, "ilogic");
    run_wb(7'b0110111, 3'b010, "u");

    // Illegal opcode: TRAP held 20 cycles whatever the inputs do.
    cyc(1'b1, 1'b1, JUNK, e_fetch(1'b1), "ill_fetch");
    cyc(1'b1, 1'b1, 7'b1111111, e_zero(), "ill_decode");
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 1'(i % 2), 7'b0110011, e_trap(), "trap_hold");
    cyc(1'b0, 1'b0, JUNK, e_zero(), "trap_reset");
    cyc(1'b1, 1'b0, JUNK, e_fetch(1'b0), "trap_exit_fetch");

    // Reset during a MEMORY wait drops outputs in the same cycle.
    cyc(1'b1, 1'b1, JUNK, e_fetch(1'b1), "rm_fetch");
    cyc(1'b1, 1'b0, 7'b0000011, e_zero(), "rm_decode");
    cyc(1'b1, 1'b0, JUNK, e_exec(3'b100), "rm_exec");
    cyc(1'b1, 1'b0, JUNK, e_mem(1'b1, 1'b0), "rm_mem_w");
    cyc(1'b0, 1'b0, JUNK, e_zero(), "rm_reset");
    cyc(1'b1, 1'b0, JUNK, e_fetch(1'b0), "rm_refetch");

    // Reset during a FETCH with ready high suppresses the load pulses.
    cyc(1'b0, 1'b1, JUNK, e_zero(), "rf_reset");
    run_wb(7'b0110011, 3'b000, "r2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The module SHALL have these ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- OP_i  input  7  opcode field from instruction register
- Mem_Ready_i  input  1  memory access complete this cycle
- PC_Write_o  output  1  unconditional PC load
- PC_Write_Cond_o  output  1  PC load if ALU zero/branch-taken
- PC_Src_o  output  2  00 ALU (PC+4), 01 jump target, 10 JALR ALU result
- Old_PC_Write_o  output  1  capture fetch PC
- IorD_o  output  1  0 instruction address, 1 data address
- Mem_Read_o  output  1  memory read request
- Mem_Write_o  output  1  memory write request
- IR_Write_o  output  1  load instruction register
- Reg_Write_o  output  1  register file write
- Mem_to_Reg_o  output  2  00 ALU, 01 memory, 10 PC+4
- ALU_Src_A_o  output  1  0 PC, 1 rs1
- ALU_Src_B_o  output  2  00 rs2, 01 constant 4, 10 immediate
- ALU_Op_o  output  3  instruction-class code
- Instr_Done_o  output  1  one-cycle retire pulse
- Illegal_o  output  1  sticky illegal-opcode flag

Function
REQ-002 The FSM SHALL have states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and TRAP.
REQ-003 Opcodes: R 0110011, I-logic 0010011, U 0110111, S 0100011, Load 0000011, B 1100011, J 1101111, JALR 1100111.
REQ-004 ALU_Op codes SHALL be R 000, I-logic 001, U 010, S 011, Load 100, B 101, J 110, JALR 111; FETCH SHALL drive 100 (add).
REQ-005 In FETCH: Mem_Read_o=1, IorD_o=0, ALU_Src_A_o=0, ALU_Src_B_o=01, PC_Src_o=00. State SHALL be held while Mem_Ready_i=0.
REQ-006 In FETCH with Mem_Ready_i=1: IR_Write_o, PC_Write_o and Old_PC_Write_o SHALL pulse for exactly that cycle; next state is DECODE.
REQ-007 DECODE SHALL last one cycle and register OP_i into an internal opcode register.
REQ-008 An unlisted opcode in DECODE SHALL go to TRAP; TRAP SHALL set Illegal_o=1, keep all other outputs 0, and exit only on reset.
REQ-009 EXECUTE SHALL last one cycle and drive ALU_Op_o for the latched class. ALU_Src_A_o=1 except U, J and JALR-link. ALU_Src_B_o=00 for R/B and 10 otherwise.
REQ-010 EXECUTE for B SHALL assert PC_Write_Cond_o=1 and PC_Src_o=01, then return to FETCH with Instr_Done_o=1.
REQ-011 EXECUTE SHALL next go to MEMORY for Load/S and to WRITEBACK for R, I-logic, U, J and JALR.
REQ-012 MEMORY SHALL drive IorD_o=1, plus Mem_Read_o (Load) or Mem_Write_o (S), held until Mem_Ready_i=1.
REQ-013 On MEMORY completion, S SHALL go to FETCH with Instr_Done_o=1; Load SHALL go to WRITEBACK.
REQ-014 WRITEBACK SHALL last one cycle with Reg_Write_o=1 and Instr_Done_o=1, then go to FETCH.
REQ-015 WRITEBACK Mem_to_Reg_o SHALL be 01 for Load, 10 for J/JALR, and 00 otherwise.
REQ-016 WRITEBACK for J SHALL assert PC_Write_o with PC_Src_o=01; for JALR, PC_Write_o with PC_Src_o=10.
REQ-017 All outputs SHALL be decoded from current state, latched opcode and Mem_Ready_i only. Outputs not named for a state SHALL be 0.
REQ-018 Mem_Read_o and Mem_Write_o SHALL never be 1 in the same cycle.
REQ-019 At most one of PC_Write_o and PC_Write_Cond_o SHALL be 1 in any cycle.

Reset
REQ-020 While reset=0 at a rising clk edge, state SHALL become FETCH, the opcode register SHALL become 0000000 and Illegal_o SHALL clear.
REQ-021 While reset=0, all outputs SHALL be 0, including mid-MEMORY or mid-FETCH wait states.
REQ-022 The first FETCH request SHALL appear in the first cycle after reset returns to 1.

Structure
REQ-023 The opcode constants, ALU_Op codes and state encoding SHALL reside in a shared package riscv_ctrl_pkg, also used by the single-cycle control unit.
REQ-024 Opcode-to-class mapping and the legal check SHALL be one sub-module, op_class_decoder.

Verification
REQ-025 R-type 0110011 with Mem_Ready_i=1 in FETCH -> 4 cycles FETCH/DECODE/EXECUTE/WRITEBACK; Reg_Write_o=1 and Mem_to_Reg_o=00 in cycle 4; Instr_Done_o in cycle 4.
REQ-026 Load 0000011 with memory ready after 2 wait cycles in both FETCH and MEMORY -> 9 cycles total; Mem_Read_o=1, IorD_o=1 held 3 cycles in MEMORY; WRITEBACK Mem_to_Reg_o=01.
REQ-027 Store 0100011 -> Mem_Write_o=1 only in MEMORY; Reg_Write_o never 1; retire after MEMORY completes.
REQ-028 B 1100011 -> 3 cycles; EXECUTE shows PC_Write_Cond_o=1, PC_Src_o=01, ALU_Op_o=101; J and JALR show PC_Src_o=01 and 10 respectively with Mem_to_Reg_o=10.
REQ-029 Opcode 1111111 -> TRAP after DECODE with Illegal_o=1 held 20 cycles; reset=0 for one cycle -> FETCH with Illegal_o=0.
REQ-030 reset=0 asserted during a MEMORY wait -> outputs 0 the same cycle; after release, FETCH with Mem_Read_o=1 and IorD_o=0.
